main_memory_burst: RTL and testbench

- Main-memory model and block-fetch engine that sits directly downstream of the direct-mapped data cache controller.
- On a cache miss the controller issues one block request.
- After a fixed access latency, this block returns the addressed 4-word block as a back-to-back burst, one word per cycle, which the cache writes into its data array before raising its finish strobe.
- Read-only: it services refills only.

---
 rtl/cache_mem_pkg.sv | 12 +
 rtl/mem_array_sync.sv | 14 +
 rtl/main_memory_burst.sv | 99 +++++++++
 tb/tb_main_memory_burst.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: geometry and FSM states shared by the data cache and the main-memory model
package cache_mem_pkg;

    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 32;
    localparam int BLOCK_WORDS  = 4;
    localparam int OFFSET_W     = 2;
    localparam int BLOCK_ADDR_W = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

endpackage

// File: rtl/mem_array_sync.sv
// mem_array_sync: read-only word array with a registered read port and identity contents
module mem_array_sync #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'(i);
  always_ff @(posedge clk) q <= mem[addr];
endmodule

// File: rtl/main_memory_burst.sv
// main_memory_burst: fixed-latency block fetch returning one cache block as a one-word-per-cycle burst
module main_memory_burst #(
    parameter int ADDR_W      = cache_mem_pkg::ADDR_W,
    parameter int DATA_W      = cache_mem_pkg::DATA_W,
    parameter int BLOCK_WORDS = cache_mem_pkg::BLOCK_WORDS,
    parameter int LATENCY     = 4,
    parameter     INIT_FILE   = ""
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0] req_block_addr,
    output logic                                  rd_valid,
    output logic [DATA_W-1:0]                     rd_data,
    output logic [$clog2(BLOCK_WORDS)-1:0]        rd_word_idx,
    output logic                                  rd_last,
    output logic                                  busy
);

    import cache_mem_pkg::*;

    localparam int OW = $clog2(BLOCK_WORDS);
    localparam logic [OW-1:0] ZERO_IDX = '0;
    localparam logic [OW-1:0] ONE_IDX  = OW'(1);
    localparam logic [OW-1:0] LAST_IDX = OW'(BLOCK_WORDS - 1);
    localparam logic [3:0]    LAT_LOAD = 4'(LATENCY - 1);

    state_t               state;
    logic [3:0]           lat_cnt;
    logic [ADDR_W-OW-1:0] blk;
    logic [ADDR_W-1:0]    rd_addr;
    logic [DATA_W-1:0]    q;

    // Read one word ahead: the array registers the word that becomes visible next cycle
    always_comb
        rd_addr = state == IDLE ? {req_block_addr, ZERO_IDX}
                : state == WAIT ? {blk, ZERO_IDX}
                :                 {blk, rd_word_idx + ONE_IDX};

    mem_array_sync #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk  (clk),
        .addr (rd_addr),
        .q    (q)
    );

    // Request accept, latency countdown and burst sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            blk         <= '0;
            busy        <= 1'b0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            rd_word_idx <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    blk  <= req_block_addr;
                    busy <= 1'b1;
                    if (LATENCY == 1) begin
                        state    <= BURST;
                        rd_valid <= 1'b1;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_LOAD;
                    end
                end
                WAIT: if (lat_cnt == 4'd1) begin
                    state    <= BURST;
                    rd_valid <= 1'b1;
                    lat_cnt  <= '0;
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
                BURST: if (rd_last) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    rd_valid    <= 1'b0;
                    rd_last     <= 1'b0;
                    rd_word_idx <= '0;
                end else begin
                    rd_word_idx <= rd_word_idx + ONE_IDX;
                    rd_last     <= rd_word_idx + ONE_IDX == LAST_IDX;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = !busy;
    assign rd_data   = rd_valid ? q : '0;

endmodule

// File: tb/tb_main_memory_burst.sv
// tb_main_memory_burst: directed fetches on LATENCY=4 and LATENCY=1 instances against a timing model
module tb_main_memory_burst;

    localparam int L0 = 4;
    localparam int L1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [12:0] a0 = '0, a1 = '0;
    logic        rdy0, busy0, val0, last0, rdy1, busy1, val1, last1;
    logic [31:0] d0, d1;
    logic [1:0]  idx0, idx1;

    always #5 clk = ~clk;

    main_memory_burst #(.LATENCY(L0)) dut (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_block_addr(a0),
        .rd_valid(val0), .rd_data(d0), .rd_word_idx(idx0), .rd_last(last0), .busy(busy0)
    );

    main_memory_burst #(.LATENCY(L1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_block_addr(a1),
        .rd_valid(val1), .rd_data(d1), .rd_word_idx(idx1), .rd_last(last1), .busy(busy1)
    );

    int n = 0;
    int checks = 0;
    int errors = 0;
    bit started = 0;
    bit act[2];
    int acc[2];
    int blk[2];
    int w0[$], t0[$], w1[$], t1[$];

    function automatic int lat(input int k);
        return k == 0 ? L0 : L1;
    endfunction

    // A request accepted at edge E keeps the block busy through the cycle after edge E+LATENCY+2
    function automatic bit m_busy(input int k, input int e);
        return act[k] && (e - acc[k]) < lat(k) + 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", nm, n, got, exp);
        end
    endtask

    task automatic cmp(input int k, input logic rdy, input logic bs, input logic vl,
                       input logic [31:0] d, input logic [1:0] ix, input logic lst);
        int off;
        bit eb, ev;
        eb  = m_busy(k, n);
        off = n - acc[k] - (lat(k) - 1);
        ev  = eb && off >= 0;
        chk($sformatf("req_ready%0d", k), {31'b0, rdy}, {31'b0, !eb});
        chk($sformatf("busy%0d", k), {31'b0, bs}, {31'b0, eb});
        chk($sformatf("rd_valid%0d", k), {31'b0, vl}, {31'b0, ev});
        chk($sformatf("rd_data%0d", k), d, ev ? 32'(blk[k] * 4 + off) : 32'd0);
        chk($sformatf("rd_last%0d", k), {31'b0, lst}, {31'b0, ev && off == 3});
        if (ev) chk($sformatf("rd_word_idx%0d", k), {30'b0, ix}, 32'(off));
    endtask

    // Model: count edges, apply reset, accept requests only when the model says idle
    always @(posedge clk) begin
        n++;
        if (rst) started = 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) act[k] = 0;
            else if ((k == 0 ? v0 : v1) && !m_busy(k, n - 1)) begin
                act[k] = 1;
                acc[k] = n;
                blk[k] = int'(k == 0 ? a0 : a1);
            end
        end
    end

    // Compare every cycle once reset has been seen, and log delivered words with their cycle
    always @(negedge clk) begin
        if (started) begin
            cmp(0, rdy0, busy0, val0, d0, idx0, last0);
            cmp(1, rdy1, busy1, val1, d1, idx1, last1);
            if (val0) begin w0.push_back(int'(d0)); t0.push_back(n); end
            if (val1) begin w1.push_back(int'(d1)); t1.push_back(n); end
        end
    end

    task automatic fetch0(input logic [12:0] a, output int e);
        v0 = 1'b1;
        a0 = a;
        e  = n + 1;
        w0.delete();
        t0.delete();
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic expect_words(input string nm, input int base);
        chk({nm, "_count"}, 32'(w0.size()), 32'd4);
        for (int i = 0; i < 4 && i < w0.size(); i++)
            chk($sformatf("%s_w%0d", nm, i), 32'(w0[i]), 32'(base + i));
    endtask

    initial begin
        int e;
        bit hit;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'b0, rdy0}, 32'd1);
        chk("reset_busy", {31'b0, busy0}, 32'd0);
        chk("reset_valid", {31'b0, val0}, 32'd0);
        chk("reset_data", d0, 32'd0);
        chk("reset_idx", {30'b0, idx0}, 32'd0);

        fetch0(13'd256, e);
        repeat (12) @(negedge clk);
        expect_words("blk256", 1024);
        if (t0.size() > 0) chk("blk256_latency", 32'(t0[0] - e), 32'd3);

        fetch0(13'd8191, e);
        repeat (12) @(negedge clk);
        expect_words("blk8191", 32764);

        fetch0(13'd10, e);
        repeat (4) @(negedge clk);
        v0 = 1'b1;
        a0 = 13'd5;
        @(negedge clk);
        v0 = 1'b0;
        repeat (14) @(negedge clk);
        expect_words("ignored", 40);

        fetch0(13'd2, e);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (val0 && idx0 == 2'd1) hit = 1;
            else @(negedge clk);
        end
        chk("reach_idx1", {31'b0, hit}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", {31'b0, val0}, 32'd0);
        chk("abort_ready", {31'b0, rdy0}, 32'd1);
        chk("abort_words", 32'(w0.size()), 32'd2);
        fetch0(13'd3, e);
        repeat (12) @(negedge clk);
        expect_words("after_abort", 12);

        w1.delete();
        t1.delete();
        v1 = 1'b1;
        a1 = 13'd0;
        @(negedge clk);
        a1 = 13'd1;
        repeat (5) @(negedge clk);
        v1 = 1'b0;
        repeat (10) @(negedge clk);
        chk("b2b_count", 32'(w1.size()), 32'd8);
        for (int i = 0; i < 8 && i < w1.size(); i++)
            chk($sformatf("b2b_w%0d", i), 32'(w1[i]), 32'(i));
        if (t1.size() == 8) chk("b2b_gap", 32'(t1[4] - t1[3]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
